bram_matrix_reader: RTL
=======================

// Module: bram_matrix_reader
// PURPOSE
//   Read-side master for the dual-port bram: on start, walks an ROWS x COLS fp32 matrix stored
//   row-major from base_addr and streams it out on a valid/ready interface, row order or column
//   order (transpose). Feeds the MAC array operand path. Absorbs the 1-cycle BRAM read latency
//   and downstream backpressure with a 2-entry output FIFO; never writes the BRAM.
// PARAMETERS
//   ADDR_WIDTH  4   BRAM address width; ROWS*COLS <= 2**ADDR_WIDTH
//   DATA_WIDTH  32  word width (IEEE-754 single)
//   ROWS        4   matrix rows, >= 1
//   COLS        4   matrix columns, >= 1
// PORTS
//   clk         in   1           rising-edge clock
//   rst_n       in   1           asynchronous active-low reset
//   start       in   1           begin a transfer; sampled only in IDLE
//   base_addr   in   ADDR_WIDTH  address of element (0,0); sampled with start
//   transpose   in   1           0: row order, 1: column order; sampled with start
//   busy        out  1           transfer in progress
//   done        out  1           1-cycle pulse after final beat accepted
//   bram_en     out  1           BRAM port enable (read request)
//   bram_we     out  1           constant 0
//   bram_addr   out  ADDR_WIDTH  BRAM read address
//   bram_dout   in   DATA_WIDTH  BRAM read data, valid 1 cycle after bram_en
//   m_valid     out  1           stream data valid
//   m_ready     in   1           stream sink ready
//   m_data      out  DATA_WIDTH  matrix element
//   m_vec_last  out  1           last element of current row (T=0) / column (T=1)
//   m_last      out  1           last element of matrix
// BEHAVIOUR
// - Reset (async, any state): IDLE; busy, done, bram_en, bram_we, m_valid, m_vec_last, m_last = 0;
//   bram_addr, m_data = 0; FIFO emptied, in-flight read discarded, counters cleared.
// - FSM: IDLE -(start)-> ISSUE -(last address issued)-> DRAIN -(final handshake)-> DONE -> IDLE.
//   DONE lasts exactly 1 cycle: done=1, busy=0. busy=1 in ISSUE and DRAIN. start outside IDLE ignored.
// - Addressing: element (r,c) at (base_addr + r*COLS + c) mod 2**ADDR_WIDTH (wraps, no error).
//   T=0: c inner, r outer. T=1: r inner, c outer. Exactly ROWS*COLS reads issued per transfer.
// - Credit rule: issue a read (bram_en=1) in a cycle only if fifo_count + inflight - pop < 2,
//   pop = m_valid & m_ready this cycle. inflight = bram_en of previous cycle. Never overflow FIFO.
// - Read data captured into FIFO at the edge after the bram_en cycle; tags (vec_last, last)
//   travel with the request, not recomputed at output.
// - Latency: start sampled at edge k -> bram_en high cycle after k -> m_valid high after edge k+2.
//   With m_ready=1 throughout: one beat per cycle, ROWS*COLS consecutive beats, done high after
//   edge k+2+ROWS*COLS.
// - Stream rules: while m_valid & !m_ready, m_data/m_vec_last/m_last held stable; m_valid never
//   drops without handshake. m_valid independent of m_ready (no comb path ready->valid).
// - ROWS=COLS=1: single beat with m_vec_last=m_last=1.
// - start in the DONE cycle ignored; new start accepted next cycle (IDLE).
// TESTING (BRAM model preloaded mem[i]=32'h0000_0100+i; 4x4 unless noted)
// - base=0,T=0,m_ready=1 -> data 100..10F in order, m_vec_last on 103,107,10B,10F, m_last on 10F,
//   m_valid first high 2 cycles after start edge, 16 consecutive beats, then done pulse.
// - base=0,T=1 -> 100,104,108,10C,101,...,10F; m_vec_last every 4th beat; m_last on 10F.
// - base=4'hE,T=0 -> addresses wrap: 10E,10F,100,...,10D; bram_we stays 0 throughout.
// - random m_ready (~50%) -> same sequence as case 1, data stable while stalled, no lost or
//   duplicated beat, bram_en never asserted with 2 words held/in flight.
// - rst_n low after 5 beats accepted -> all outputs 0 asynchronously; after release, new start
//   gives full sequence from element 0.
// - start pulsed while busy -> ignored, sequence unchanged; ROWS=COLS=1 -> one beat, both lasts.

Source files
------------

// File: rtl/bram_matrix_reader_if.sv
// Bus bundle between the matrix reader, its BRAM read port and the
// downstream operand stream.
//   bram_en / bram_we / bram_addr : BRAM port controls driven by the reader
//   bram_dout                     : BRAM read data, valid one cycle after bram_en
//   m_valid / m_ready             : stream handshake
//   m_data / m_vec_last / m_last  : stream payload and row/column/matrix tags
// master = reader side, slave = memory + sink side.
interface bram_matrix_reader_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);
  logic                  bram_en;
  logic                  bram_we;
  logic [ADDR_WIDTH-1:0] bram_addr;
  logic [DATA_WIDTH-1:0] bram_dout;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_vec_last;
  logic                  m_last;

  modport master (
    output bram_en, bram_we, bram_addr, m_valid, m_data, m_vec_last, m_last,
    input  bram_dout, m_ready
  );

  modport slave (
    input  bram_en, bram_we, bram_addr, m_valid, m_data, m_vec_last, m_last,
    output bram_dout, m_ready
  );
endinterface

// File: rtl/bram_matrix_reader.sv
// Read-side BRAM master: on start, walks a ROWS x COLS matrix stored row-major
// from base_addr and streams it out, in row order or (transpose=1) column order.
// A 2-entry output FIFO absorbs the one-cycle BRAM read latency and downstream
// backpressure; reads are only issued when a FIFO slot is guaranteed.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : begin a transfer (sampled only in IDLE)
//   base_addr   : address of element (0,0), sampled with start
//   transpose   : 0 row order, 1 column order, sampled with start
//   busy        : transfer in progress (ISSUE or DRAIN)
//   done        : one-cycle pulse after the final beat is accepted
//   bus         : BRAM read port and output stream (master modport)
module bram_matrix_reader #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ROWS       = 4,
  parameter int COLS       = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  transpose,
  output logic                  busy,
  output logic                  done,
  bram_matrix_reader_if.master  bus
);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t                state, state_nx;
  logic [RW-1:0]         r_cnt;
  logic [CW-1:0]         c_cnt;
  logic [ADDR_WIDTH-1:0] base_q;
  logic                  trans_q;
  logic                  inflight_q;
  logic                  tag_vl_q;
  logic                  tag_last_q;
  logic [DATA_WIDTH-1:0] head_data, tail_data;
  logic                  head_vl, head_last, tail_vl, tail_last;
  logic [1:0]            fifo_count;
  logic [2:0]            occupancy;
  logic                  r_end, c_end, issue_vl, issue_last;
  logic                  issue, push, pop;
  logic [ADDR_WIDTH-1:0] cur_addr;

  assign r_end      = (r_cnt == RW'(ROWS - 1));
  assign c_end      = (c_cnt == CW'(COLS - 1));
  assign issue_vl   = trans_q ? r_end : c_end;
  // The final element is (ROWS-1, COLS-1) in both walk orders.
  assign issue_last = r_end & c_end;
  // Truncation to ADDR_WIDTH gives the intended modulo wrap.
  assign cur_addr   = base_q + ADDR_WIDTH'(r_cnt) * ADDR_WIDTH'(COLS) + ADDR_WIDTH'(c_cnt);

  assign push = inflight_q;
  assign pop  = bus.m_valid & bus.m_ready;
  // Words that will be held once this cycle's pop and the pending read land.
  assign occupancy = 3'(fifo_count) + 3'(inflight_q) - 3'(pop);

  assign bus.m_valid    = (fifo_count != 2'd0);
  assign bus.m_data     = head_data;
  assign bus.m_vec_last = bus.m_valid & head_vl;
  assign bus.m_last     = bus.m_valid & head_last;
  assign bus.bram_en    = issue;
  assign bus.bram_we    = 1'b0;
  assign bus.bram_addr  = issue ? cur_addr : '0;
  assign busy           = (state == S_ISSUE) || (state == S_DRAIN);
  assign done           = (state == S_DONE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next state and read issue; a read goes out only when a FIFO slot is
  // guaranteed for it one cycle later.
  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    case (state)
      S_IDLE:  if (start) state_nx = S_ISSUE;
      S_ISSUE: begin
        if (occupancy < 3'd2) begin
          issue = 1'b1;
          if (issue_last) state_nx = S_DRAIN;
        end
      end
      S_DRAIN: if (pop && head_last) state_nx = S_DONE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Walk counters, captured transfer parameters and the tag pipeline that
  // carries vec_last/last alongside the outstanding read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      c_cnt      <= '0;
      base_q     <= '0;
      trans_q    <= 1'b0;
      inflight_q <= 1'b0;
      tag_vl_q   <= 1'b0;
      tag_last_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      tag_vl_q   <= issue_vl;
      tag_last_q <= issue_last;
      if (state == S_IDLE && start) begin
        base_q  <= base_addr;
        trans_q <= transpose;
        r_cnt   <= '0;
        c_cnt   <= '0;
      end else if (issue) begin
        if (!trans_q) begin
          if (c_end) begin
            c_cnt <= '0;
            r_cnt <= r_cnt + RW'(1);
          end else begin
            c_cnt <= c_cnt + CW'(1);
          end
        end else begin
          if (r_end) begin
            r_cnt <= '0;
            c_cnt <= c_cnt + CW'(1);
          end else begin
            r_cnt <= r_cnt + RW'(1);
          end
        end
      end
    end
  end

  // Two-entry FIFO kept as head/tail registers; the head drives the stream
  // directly so the payload stays put while the sink stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_data  <= '0;
      head_vl    <= 1'b0;
      head_last  <= 1'b0;
      tail_data  <= '0;
      tail_vl    <= 1'b0;
      tail_last  <= 1'b0;
      fifo_count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (fifo_count == 2'd0) begin
            head_data <= bus.bram_dout;
            head_vl   <= tag_vl_q;
            head_last <= tag_last_q;
          end else begin
            tail_data <= bus.bram_dout;
            tail_vl   <= tag_vl_q;
            tail_last <= tag_last_q;
          end
          fifo_count <= fifo_count + 2'd1;
        end
        2'b01: begin
          head_data  <= tail_data;
          head_vl    <= tail_vl;
          head_last  <= tail_last;
          fifo_count <= fifo_count - 2'd1;
        end
        2'b11: begin
          if (fifo_count == 2'd1) begin
            head_data <= bus.bram_dout;
            head_vl   <= tag_vl_q;
            head_last <= tag_last_q;
          end else begin
            head_data <= tail_data;
            head_vl   <= tail_vl;
            head_last <= tail_last;
            tail_data <= bus.bram_dout;
            tail_vl   <= tag_vl_q;
            tail_last <= tag_last_q;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
